// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, frame-format constants and helpers for the UART
//
// Contents:
//   tx_state_t           transmit frame FSM states
//   SBIT_1/SBIT_2/SBIT_3 stop-bit count encodings of cr_sbit
//   PAR_EVEN/PAR_ODD     parity type encodings of cr_ptype
//   last_stop_idx()      index of the final stop bit for a cr_sbit code
//   parity_bit()         parity bit value for a data byte and parity type
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic [1:0] SBIT_1 = 2'b00;
  localparam logic [1:0] SBIT_2 = 2'b01;
  localparam logic [1:0] SBIT_3 = 2'b10;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Both 10 and 11 select three stop bits.
  function automatic logic [1:0] last_stop_idx(input logic [1:0] sbit);
    case (sbit)
      SBIT_1:        return 2'd0;
      SBIT_2:        return 2'd1;
      SBIT_3, 2'b11: return 2'd2;
      default:       return 2'd2;
    endcase
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input logic ptype);
    case (ptype)
      PAR_EVEN: return ^data;
      PAR_ODD:  return ~^data;
      default:  return ^data;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - TX FIFO read port between the FIFO and the transmit engine
//
// Signals:
//   fifo_tx_empty  FIFO empty flag
//   fifo_tx_data   FIFO head word, first-word-fall-through
//   fifo_tx_read   pop strobe, one cycle per byte
// Modports:
//   master  transmit engine (issues pops)
//   slave   FIFO (supplies data)
interface uart_tx_if;

  logic       fifo_tx_empty;
  logic [7:0] fifo_tx_data;
  logic       fifo_tx_read;

  modport master (
    input  fifo_tx_empty,
    input  fifo_tx_data,
    output fifo_tx_read
  );

  modport slave (
    output fifo_tx_empty,
    output fifo_tx_data,
    input  fifo_tx_read
  );

endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - fractional baud-tick generator
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   cr_baud_freq   accumulator increment
//   cr_baud_limit  accumulator limit
//   tick           baud tick, rate f_clk*freq/(freq+limit)
module uart_baud_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cr_baud_freq,
  input  logic [15:0] cr_baud_limit,
  output logic        tick
);

  // acc stays below limit+freq, so 17 bits never overflow.
  logic [16:0] acc;

  assign tick = (acc >= {1'b0, cr_baud_limit});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (tick) begin
      acc <= acc - {1'b0, cr_baud_limit};
    end else begin
      acc <= acc + {1'b0, cr_baud_freq};
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmit engine
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   cr_pbit        parity enable
//   cr_ptype       parity type (0 even, 1 odd)
//   cr_sbit        stop bits (00 one, 01 two, 1x three)
//   cr_baud_freq   baud accumulator increment
//   cr_baud_limit  baud accumulator limit
//   fifo           TX FIFO read port (master side)
//   txd            serial line, idle high, registered
//   tx_busy        frame in progress, registered
module uart_tx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cr_pbit,
  input  logic        cr_ptype,
  input  logic [1:0]  cr_sbit,
  input  logic [15:0] cr_baud_freq,
  input  logic [15:0] cr_baud_limit,
  uart_tx_if.master   fifo,
  output logic        txd,
  output logic        tx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);

  logic            tick;
  tx_state_t       state;
  logic [7:0]      shreg;
  logic            pbit_q;
  logic            par_q;
  logic [1:0]      last_stop_q;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [1:0]      stop_idx;
  logic            bit_end;

  uart_baud_gen u_baud (
    .clk           (clk),
    .reset         (reset),
    .cr_baud_freq  (cr_baud_freq),
    .cr_baud_limit (cr_baud_limit),
    .tick          (tick)
  );

  // Gated by reset so the FIFO cannot be popped while reset is held.
  assign fifo.fifo_tx_read = (state == IDLE) && !fifo.fifo_tx_empty && !reset;

  // Current bit finishes on the clock carrying the OVERSAMPLE-th tick.
  assign bit_end = tick && (cnt == LAST_TICK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      txd         <= 1'b1;
      tx_busy     <= 1'b0;
      shreg       <= '0;
      pbit_q      <= 1'b0;
      par_q       <= 1'b0;
      last_stop_q <= '0;
      cnt         <= '0;
      bit_idx     <= '0;
      stop_idx    <= '0;
    end else if (state == IDLE) begin
      if (!fifo.fifo_tx_empty) begin
        // Whole frame format is frozen here; later cr_* edits wait for the next byte.
        shreg       <= fifo.fifo_tx_data;
        pbit_q      <= cr_pbit;
        par_q       <= parity_bit(fifo.fifo_tx_data, cr_ptype);
        last_stop_q <= last_stop_idx(cr_sbit);
        cnt         <= '0;
        bit_idx     <= '0;
        stop_idx    <= '0;
        state       <= START;
        txd         <= 1'b0;
        tx_busy     <= 1'b1;
      end
    end else begin
      if (tick) begin
        cnt <= bit_end ? '0 : cnt + 1'b1;
      end
      if (bit_end) begin
        case (state)
          START: begin
            state <= DATA;
            txd   <= shreg[0];
          end
          DATA: begin
            if (bit_idx == 3'd7) begin
              if (pbit_q) begin
                state <= PARITY;
                txd   <= par_q;
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              txd     <= shreg[1];
            end
          end
          PARITY: begin
            state <= STOP;
            txd   <= 1'b1;
          end
          STOP: begin
            if (stop_idx == last_stop_q) begin
              state   <= IDLE;
              txd     <= 1'b1;
              tx_busy <= 1'b0;
            end else begin
              stop_idx <= stop_idx + 2'd1;
            end
          end
          default: begin
            state   <= IDLE;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cr_pbit;
  logic        cr_ptype;
  logic [1:0]  cr_sbit;
  logic [15:0] cr_baud_freq;
  logic [15:0] cr_baud_limit;
  logic        txd;
  logic        tx_busy;

  uart_tx_if txif();

  uart_tx #(.OVERSAMPLE(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .cr_pbit       (cr_pbit),
    .cr_ptype      (cr_ptype),
    .cr_sbit       (cr_sbit),
    .cr_baud_freq  (cr_baud_freq),
    .cr_baud_limit (cr_baud_limit),
    .fifo          (txif.master),
    .txd           (txd),
    .tx_busy       (tx_busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         passes = 0;
  int         cyc = 0;
  int         pops = 0;
  int         last_rise = 0;
  logic       prev_txd = 1'b1;
  logic [7:0] q[$];
  int         edges[$];

  task automatic refresh();
    txif.fifo_tx_empty = (q.size() == 0);
    txif.fifo_tx_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    refresh();
  endtask

  // FIFO model: a pop seen at a clock edge retires the head just after it.
  always @(posedge clk) begin
    cyc++;
    if (txif.fifo_tx_read === 1'b1) begin
      #1;
      if (q.size() != 0) void'(q.pop_front());
      pops++;
      refresh();
    end
  end

  always @(negedge clk) begin
    if (txd !== prev_txd) begin
      edges.push_back(cyc);
      if (txd === 1'b1) last_rise = cyc;
      prev_txd = txd;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
  endtask

  task automatic chk_range(input string tag, input int got, input int lo, input int hi);
    checks++;
    assert (got >= lo && got <= hi) passes++;
    else $error("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
  endtask

  task automatic wait_fall(input string tag, output int at);
    int found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        found = 1;
        break;
      end
    end
    at = cyc;
    chk(tag, found, 1);
  endtask

  task automatic wait_idle(input string tag, output int at);
    int found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx_busy === 1'b0) begin
        found = 1;
        break;
      end
    end
    at = cyc;
    chk(tag, found, 1);
  endtask

  // Called right after the start edge is seen; samples near each bit centre.
  task automatic rx_frame(input int nbits, output logic [15:0] bits);
    bits = '0;
    repeat (15) @(negedge clk);
    bits[0] = txd;
    for (int i = 1; i < nbits; i++) begin
      repeat (32) @(negedge clk);
      bits[i] = txd;
    end
  endtask

  initial begin
    int f, f2, c, s, bad;
    logic [15:0] b;
    int exp_gap[3];
    exp_gap = '{65, 97, 97};

    reset         = 1'b1;
    cr_pbit       = 1'b0;
    cr_ptype      = PAR_EVEN;
    cr_sbit       = SBIT_1;
    cr_baud_freq  = 16'd1;
    cr_baud_limit = 16'd1;
    refresh();
    push(8'h55);
    repeat (3) @(negedge clk);
    chk("reset_txd", txd, 1);
    chk("reset_busy", tx_busy, 0);
    chk("reset_no_read", txif.fifo_tx_read, 0);
    chk("reset_no_pop", pops, 0);

    // 8N1, 0x55
    edges.delete();
    reset = 1'b0;
    wait_fall("8n1_start_seen", f);
    chk("8n1_busy_at_start", tx_busy, 1);
    rx_frame(10, b);
    chk("8n1_bits", int'(b), int'({1'b1, 8'h55, 1'b0}));
    wait_idle("8n1_idle_seen", c);
    s = (edges.size() > 9) ? edges[1] - edges[0] : -1;
    chk_range("8n1_start_len", s, 31, 32);
    chk("8n1_data_span", (edges.size() > 9) ? edges[9] - edges[1] : -1, 256);
    chk("8n1_busy_len", c - f, s + 288);
    chk("8n1_pops", pops, 1);

    // parity even then odd, 0x07
    cr_pbit  = 1'b1;
    cr_ptype = PAR_EVEN;
    push(8'h07);
    wait_fall("par_even_start", f);
    rx_frame(11, b);
    chk("par_even_bits", int'(b), int'({1'b1, 1'b1, 8'h07, 1'b0}));
    wait_idle("par_even_idle", c);
    chk_range("par_even_len", c - f, 351, 352);
    cr_ptype = PAR_ODD;
    push(8'h07);
    wait_fall("par_odd_start", f);
    rx_frame(11, b);
    chk("par_odd_bits", int'(b), int'({1'b1, 1'b0, 8'h07, 1'b0}));
    wait_idle("par_odd_idle", c);
    chk("par_pops", pops, 3);

    // stop-bit counts: high time from stop entry to next start
    cr_pbit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cr_sbit = 2'(k + 1);
      push(8'h00);
      push(8'h00);
      wait_fall("stop_f1", f);
      rx_frame(10, b);
      chk("stop_f1_bits", int'(b), int'({1'b1, 8'h00, 1'b0}));
      wait_fall("stop_f2", f2);
      chk($sformatf("stop_gap_sbit%0d", k + 1), f2 - last_rise, exp_gap[k]);
      wait_idle("stop_idle", c);
    end
    chk("stop_pops", pops, 9);

    // back-to-back, ptype toggled during first frame
    cr_sbit  = SBIT_1;
    cr_pbit  = 1'b1;
    cr_ptype = PAR_EVEN;
    push(8'hA5);
    push(8'h3C);
    wait_fall("b2b_f1", f);
    cr_ptype = PAR_ODD;
    rx_frame(11, b);
    chk("b2b_f1_bits", int'(b), int'({1'b1, 1'b0, 8'hA5, 1'b0}));
    wait_fall("b2b_f2", f2);
    chk("b2b_gap", f2 - last_rise, 33);
    rx_frame(11, b);
    chk("b2b_f2_bits", int'(b), int'({1'b1, 1'b1, 8'h3C, 1'b0}));
    wait_idle("b2b_idle", c);
    chk("b2b_pops", pops, 11);

    // reset during data bit 3 of 0xFF
    cr_pbit  = 1'b0;
    cr_ptype = PAR_EVEN;
    push(8'hFF);
    push(8'h0F);
    wait_fall("rst_start", f);
    repeat (140) @(negedge clk);
    chk("rst_pre_txd", txd, 1);
    chk("rst_pre_busy", tx_busy, 1);
    reset = 1'b1;
    #1;
    chk("rst_txd_now", txd, 1);
    chk("rst_busy_now", tx_busy, 0);
    chk("rst_read_held", txif.fifo_tx_read, 0);
    repeat (5) @(negedge clk);
    chk("rst_no_pop", pops, 12);
    reset = 1'b0;
    wait_fall("rst_next_start", f);
    rx_frame(10, b);
    chk("rst_next_bits", int'(b), int'({1'b1, 8'h0F, 1'b0}));
    wait_idle("rst_next_idle", c);
    chk("rst_pops", pops, 13);

    // empty FIFO stays quiet
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || txif.fifo_tx_read !== 1'b0) bad++;
    end
    chk("empty_quiet", bad, 0);
    chk("empty_pops", pops, 13);

    // zero increment stalls a started frame
    cr_baud_freq  = 16'd0;
    cr_baud_limit = 16'd5;
    push(8'h00);
    wait_fall("stall_start", f);
    repeat (300) @(negedge clk);
    chk("stall_txd", txd, 0);
    chk("stall_busy", tx_busy, 1);
    chk("stall_pops", pops, 14);
    reset = 1'b1;
    #1;
    chk("stall_reset_txd", txd, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
